// File: rtl/stream_seq_pkg.sv
// Shared types and constants for the stream transfer sequencer.
// Holds the sequencer state encoding and the command opcode values.
package stream_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STORE = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic OP_STORE = 1'b0;
    localparam logic OP_LOAD  = 1'b1;

endpackage

// File: rtl/stream_beat_counter.sv
// Transfer length register and beat counter for one sequencer command.
// o_is_last flags the beat that must carry TLAST on the forwarded stream.
module stream_beat_counter #(
    parameter int STORAGE_IDX_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_start,
    input  logic [STORAGE_IDX_WIDTH:0]   i_len,
    input  logic                         i_beat,
    output logic                         o_is_last
);

    logic [STORAGE_IDX_WIDTH:0] r_len;
    logic [STORAGE_IDX_WIDTH:0] r_beat_cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len      <= '0;
            r_beat_cnt <= '0;
        end else if (i_start) begin
            r_len      <= i_len;
            r_beat_cnt <= '0;
        end else if (i_beat) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
        end
    end

    // Only meaningful while a non-empty transfer is active (len >= 1).
    assign o_is_last = (r_beat_cnt == (r_len - 1'b1));

endmodule

// File: rtl/stream_xfer_sequencer.sv
// Command-driven AXI-Stream sequencer steering host<->streamer beats with forced TLAST.
// Zero-latency combinational muxing; the FSM only tracks phase, length and error status.
module stream_xfer_sequencer
    import stream_seq_pkg::*;
#(
    parameter int DATA_WIDTH        = 32,
    parameter int STORAGE_IDX_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_op,
    input  logic [STORAGE_IDX_WIDTH:0]   cmd_len,
    input  logic                         abort,
    output logic                         busy,
    output logic                         done,
    output logic                         err,

    input  logic [DATA_WIDTH-1:0]        H_S_AXI_TDATA,
    input  logic [DATA_WIDTH/8-1:0]      H_S_AXI_TKEEP,
    input  logic                         H_S_AXI_TVALID,
    input  logic                         H_S_AXI_TLAST,
    output logic                         H_S_AXI_TREADY,

    output logic [DATA_WIDTH-1:0]        ST_M_AXI_TDATA,
    output logic [DATA_WIDTH/8-1:0]      ST_M_AXI_TKEEP,
    output logic                         ST_M_AXI_TVALID,
    output logic                         ST_M_AXI_TLAST,
    input  logic                         ST_M_AXI_TREADY,

    input  logic [DATA_WIDTH-1:0]        ST_S_AXI_TDATA,
    input  logic [DATA_WIDTH/8-1:0]      ST_S_AXI_TKEEP,
    input  logic                         ST_S_AXI_TVALID,
    input  logic                         ST_S_AXI_TLAST,
    output logic                         ST_S_AXI_TREADY,

    output logic [DATA_WIDTH-1:0]        H_M_AXI_TDATA,
    output logic [DATA_WIDTH/8-1:0]      H_M_AXI_TKEEP,
    output logic                         H_M_AXI_TVALID,
    output logic                         H_M_AXI_TLAST,
    input  logic                         H_M_AXI_TREADY
);

    state_t r_state;
    state_t w_next_state;
    logic   r_ready_en;
    logic   r_err_flag;

    logic   w_accept;
    logic   w_start;
    logic   w_active;
    logic   w_beat;
    logic   w_src_last;
    logic   w_is_last;
    logic   w_err_set;

    assign w_active = (r_state == STORE) || (r_state == LOAD);
    assign w_accept = cmd_valid && cmd_ready;
    assign w_start  = w_accept && (cmd_len != '0);
    assign w_err_set = w_active && (abort || (w_beat && (w_src_last != w_is_last)));

    stream_beat_counter #(
        .STORAGE_IDX_WIDTH (STORAGE_IDX_WIDTH)
    ) u_beat_counter (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_start),
        .i_len     (cmd_len),
        .i_beat    (w_beat),
        .o_is_last (w_is_last)
    );

    // r_ready_en holds cmd_ready low until the first edge after reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ready_en <= 1'b0;
            r_err_flag <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_ready_en <= 1'b1;
            if (w_accept) begin
                r_err_flag <= 1'b0;
            end else if (w_err_set) begin
                r_err_flag <= 1'b1;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (cmd_len == '0) begin
                        w_next_state = DONE;
                    end else if (cmd_op == OP_LOAD) begin
                        w_next_state = LOAD;
                    end else begin
                        w_next_state = STORE;
                    end
                end
            end
            STORE, LOAD: begin
                if (abort || (w_beat && w_is_last)) begin
                    w_next_state = DONE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        H_S_AXI_TREADY  = 1'b0;
        ST_M_AXI_TDATA  = '0;
        ST_M_AXI_TKEEP  = '0;
        ST_M_AXI_TVALID = 1'b0;
        ST_M_AXI_TLAST  = 1'b0;
        ST_S_AXI_TREADY = 1'b0;
        H_M_AXI_TDATA   = '0;
        H_M_AXI_TKEEP   = '0;
        H_M_AXI_TVALID  = 1'b0;
        H_M_AXI_TLAST   = 1'b0;
        w_beat          = 1'b0;
        w_src_last      = 1'b0;
        case (r_state)
            STORE: begin
                ST_M_AXI_TDATA  = H_S_AXI_TDATA;
                ST_M_AXI_TKEEP  = H_S_AXI_TKEEP;
                ST_M_AXI_TVALID = H_S_AXI_TVALID;
                ST_M_AXI_TLAST  = w_is_last;
                H_S_AXI_TREADY  = ST_M_AXI_TREADY;
                w_beat          = H_S_AXI_TVALID && ST_M_AXI_TREADY;
                w_src_last      = H_S_AXI_TLAST;
            end
            LOAD: begin
                H_M_AXI_TDATA   = ST_S_AXI_TDATA;
                H_M_AXI_TKEEP   = ST_S_AXI_TKEEP;
                H_M_AXI_TVALID  = ST_S_AXI_TVALID;
                H_M_AXI_TLAST   = w_is_last;
                ST_S_AXI_TREADY = H_M_AXI_TREADY;
                w_beat          = ST_S_AXI_TVALID && H_M_AXI_TREADY;
                w_src_last      = ST_S_AXI_TLAST;
            end
            default: ;
        endcase
    end

    assign cmd_ready = r_ready_en && (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign err       = (r_state == DONE) && r_err_flag;

endmodule

// File: tb/tb_stream_xfer_sequencer.sv
// Self-checking bench: directed scenarios plus randomized commands against a beat-level model.
// The model tracks expected beats, forced TLAST positions, error status and done timing.
`timescale 1ns/1ps
module tb_stream_xfer_sequencer;
    import stream_seq_pkg::*;

    localparam int DW = 32;
    localparam int IW = 10;
    localparam int KW = DW / 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_op, abort, busy, done, err;
    logic [IW:0]   cmd_len;
    logic [DW-1:0] H_S_AXI_TDATA, ST_M_AXI_TDATA, ST_S_AXI_TDATA, H_M_AXI_TDATA;
    logic [KW-1:0] H_S_AXI_TKEEP, ST_M_AXI_TKEEP, ST_S_AXI_TKEEP, H_M_AXI_TKEEP;
    logic          H_S_AXI_TVALID, H_S_AXI_TLAST, H_S_AXI_TREADY;
    logic          ST_M_AXI_TVALID, ST_M_AXI_TLAST, ST_M_AXI_TREADY;
    logic          ST_S_AXI_TVALID, ST_S_AXI_TLAST, ST_S_AXI_TREADY;
    logic          H_M_AXI_TVALID, H_M_AXI_TLAST, H_M_AXI_TREADY;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stream_xfer_sequencer #(
        .DATA_WIDTH        (DW),
        .STORAGE_IDX_WIDTH (IW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_len         (cmd_len),
        .abort           (abort),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .H_S_AXI_TDATA   (H_S_AXI_TDATA),
        .H_S_AXI_TKEEP   (H_S_AXI_TKEEP),
        .H_S_AXI_TVALID  (H_S_AXI_TVALID),
        .H_S_AXI_TLAST   (H_S_AXI_TLAST),
        .H_S_AXI_TREADY  (H_S_AXI_TREADY),
        .ST_M_AXI_TDATA  (ST_M_AXI_TDATA),
        .ST_M_AXI_TKEEP  (ST_M_AXI_TKEEP),
        .ST_M_AXI_TVALID (ST_M_AXI_TVALID),
        .ST_M_AXI_TLAST  (ST_M_AXI_TLAST),
        .ST_M_AXI_TREADY (ST_M_AXI_TREADY),
        .ST_S_AXI_TDATA  (ST_S_AXI_TDATA),
        .ST_S_AXI_TKEEP  (ST_S_AXI_TKEEP),
        .ST_S_AXI_TVALID (ST_S_AXI_TVALID),
        .ST_S_AXI_TLAST  (ST_S_AXI_TLAST),
        .ST_S_AXI_TREADY (ST_S_AXI_TREADY),
        .H_M_AXI_TDATA   (H_M_AXI_TDATA),
        .H_M_AXI_TKEEP   (H_M_AXI_TKEEP),
        .H_M_AXI_TVALID  (H_M_AXI_TVALID),
        .H_M_AXI_TLAST   (H_M_AXI_TLAST),
        .H_M_AXI_TREADY  (H_M_AXI_TREADY)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // OR of every AXIS output the sequencer drives; must be 0 outside an active phase.
    function automatic logic all_out();
        return |{H_S_AXI_TREADY, ST_M_AXI_TDATA, ST_M_AXI_TKEEP, ST_M_AXI_TVALID, ST_M_AXI_TLAST,
                 ST_S_AXI_TREADY, H_M_AXI_TDATA, H_M_AXI_TKEEP, H_M_AXI_TVALID, H_M_AXI_TLAST};
    endfunction

    // Error is due on abort or on any transferred beat whose source TLAST disagrees with "is beat len-1".
    function automatic logic exp_err(input int n_beats, input int len, input int last_idx, input logic aborted);
        logic e = aborted;
        for (int i = 0; i < n_beats; i++)
            if ((i == last_idx) != (i == len - 1)) e = 1'b1;
        return e;
    endfunction

    task automatic junk_inputs();
        H_S_AXI_TDATA   = $urandom;
        H_S_AXI_TKEEP   = KW'($urandom);
        H_S_AXI_TVALID  = 1'($urandom_range(0, 1));
        H_S_AXI_TLAST   = 1'($urandom_range(0, 1));
        ST_M_AXI_TREADY = 1'($urandom_range(0, 1));
        ST_S_AXI_TDATA  = $urandom;
        ST_S_AXI_TKEEP  = KW'($urandom);
        ST_S_AXI_TVALID = 1'($urandom_range(0, 1));
        ST_S_AXI_TLAST  = 1'($urandom_range(0, 1));
        H_M_AXI_TREADY  = 1'($urandom_range(0, 1));
    endtask

    // Entry and exit at posedge+1. vmode/rmode: 0 = always, 1 = toggle starting high, 2 = random.
    // last_idx: beat index carrying source TLAST (-1 = none). abort_k / rst_k: act once k beats are done.
    task automatic run_cmd(input string tag, input logic op, input int len, input int vmode, input int rmode,
                           input int last_idx, input int abort_k, input int rst_k);
        logic [DW-1:0] sd[$];
        logic [KW-1:0] sk[$];
        int            si = 0;
        int            cyc = 0;
        logic          done_due, done_next, aborted = 1'b0, finished = 1'b0;
        logic          src_v, sink_r, o_v, o_l, o_r, other;
        logic [DW-1:0] drv_d, o_d;
        logic [KW-1:0] drv_k, o_k;

        for (int i = 0; i < len; i++) begin
            sd.push_back($urandom);
            sk.push_back(KW'($urandom));
        end

        junk_inputs();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = (IW + 1)'(len);
        abort     = 1'($urandom_range(0, 1));
        #1;
        check($sformatf("%s.cmd_ready", tag), cmd_ready, 1);
        check($sformatf("%s.idle_quiet", tag), {busy, done, all_out()}, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;

        done_due = (len == 0);
        while (!finished) begin
            cyc++;
            if (cyc > 64 * len + 16) begin
                check($sformatf("%s.timeout", tag), 0, 1);
                reset = 1'b1; #1; reset = 1'b0;
                @(posedge clk); #1;
                return;
            end
            junk_inputs();
            done_next = 1'b0;
            src_v  = !done_due && (si < len) && ((vmode == 0) || (vmode == 1 && cyc % 2 == 1) ||
                                                 (vmode == 2 && $urandom_range(0, 1) == 1));
            sink_r = (rmode == 0) || (rmode == 1 && cyc % 2 == 1) || (rmode == 2 && $urandom_range(0, 1) == 1);
            abort  = done_due ? 1'($urandom_range(0, 1)) : 1'(abort_k == si && !aborted);
            drv_d  = (si < len) ? sd[si] : DW'($urandom);
            drv_k  = (si < len) ? sk[si] : KW'($urandom);
            if (!done_due) begin
                if (op == OP_STORE) begin
                    H_S_AXI_TVALID = src_v;  H_S_AXI_TDATA = drv_d; H_S_AXI_TKEEP = drv_k;
                    H_S_AXI_TLAST  = (si == last_idx); ST_M_AXI_TREADY = sink_r;
                end else begin
                    ST_S_AXI_TVALID = src_v; ST_S_AXI_TDATA = drv_d; ST_S_AXI_TKEEP = drv_k;
                    ST_S_AXI_TLAST  = (si == last_idx); H_M_AXI_TREADY = sink_r;
                end
            end

            if (rst_k == si && !done_due) begin
                reset = 1'b1;
                #1;
                check($sformatf("%s.rst_axis_low", tag), all_out(), 0);
                check($sformatf("%s.rst_status", tag), {cmd_ready, busy, done, err}, 0);
                repeat (2) begin
                    @(posedge clk); #1;
                    check($sformatf("%s.rst_no_done", tag), {done, all_out()}, 0);
                end
                reset = 1'b0;
                #1;
                check($sformatf("%s.rst_rel_ready", tag), cmd_ready, 0);
                @(posedge clk); #1;
                check($sformatf("%s.post_rst", tag), {cmd_ready, busy, done}, 3'b100);
                return;
            end

            #1;
            if (op == OP_STORE) begin
                o_v = ST_M_AXI_TVALID; o_d = ST_M_AXI_TDATA; o_k = ST_M_AXI_TKEEP;
                o_l = ST_M_AXI_TLAST;  o_r = H_S_AXI_TREADY;
                other = |{ST_S_AXI_TREADY, H_M_AXI_TVALID, H_M_AXI_TDATA, H_M_AXI_TKEEP, H_M_AXI_TLAST};
            end else begin
                o_v = H_M_AXI_TVALID;  o_d = H_M_AXI_TDATA;  o_k = H_M_AXI_TKEEP;
                o_l = H_M_AXI_TLAST;   o_r = ST_S_AXI_TREADY;
                other = |{H_S_AXI_TREADY, ST_M_AXI_TVALID, ST_M_AXI_TDATA, ST_M_AXI_TKEEP, ST_M_AXI_TLAST};
            end

            check($sformatf("%s.done", tag), done, done_due);
            if (done_due) begin
                check($sformatf("%s.err", tag), err, exp_err(si, len, last_idx, aborted));
                check($sformatf("%s.done_quiet", tag), {cmd_ready, busy, all_out()}, 3'b010);
                if (vmode == 0 && rmode == 0 && abort_k < 0)
                    check($sformatf("%s.done_cycle", tag), cyc, len + 1);
                finished = 1'b1;
            end else begin
                check($sformatf("%s.active", tag), {cmd_ready, busy, other}, 3'b010);
                check($sformatf("%s.vld_pass", tag), o_v, src_v);
                check($sformatf("%s.rdy_pass", tag), o_r, sink_r);
                check($sformatf("%s.data_pass", tag), {o_k, o_d}, {drv_k, drv_d});
                check($sformatf("%s.tlast", tag), o_l, (si == len - 1));
                if (src_v && sink_r) begin
                    si++;
                    if (si == len) done_next = 1'b1;
                end
                if (abort) begin
                    aborted   = 1'b1;
                    done_next = 1'b1;
                end
            end
            @(posedge clk); #1;
            done_due = done_next;
        end
        abort = 1'b0;
        check($sformatf("%s.ready_after", tag), {cmd_ready, busy, done}, 3'b100);
    endtask

    logic op_r;
    int   len_r, li_r, ak_r;

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_len   = '0;
        abort     = 1'b0;
        junk_inputs();
        #12;
        check("reset.status", {cmd_ready, busy, done, err}, 0);
        check("reset.axis", all_out(), 0);
        reset = 1'b0;
        #1;
        check("reset.rel_ready", cmd_ready, 0);
        @(posedge clk); #1;
        check("reset.first_edge_ready", cmd_ready, 1);

        run_cmd("store4",       OP_STORE, 4,    0, 0, 3,  -1, -1);
        run_cmd("load3_toggle", OP_LOAD,  3,    0, 1, 2,  -1, -1);
        run_cmd("store4_early", OP_STORE, 4,    0, 0, 1,  -1, -1);
        run_cmd("len0",         OP_STORE, 0,    0, 0, -1, -1, -1);
        run_cmd("load8_abort",  OP_LOAD,  8,    0, 0, 7,  2,  -1);
        run_cmd("load5_nolast", OP_LOAD,  5,    0, 0, -1, -1, -1);
        run_cmd("store10_rst",  OP_STORE, 10,   0, 0, 9,  -1, 5);
        run_cmd("load1",        OP_LOAD,  1,    0, 0, 0,  -1, -1);
        run_cmd("store_max",    OP_STORE, 1024, 0, 0, 1023, -1, -1);

        for (int t = 0; t < 80; t++) begin
            op_r  = 1'($urandom_range(0, 1));
            len_r = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
            li_r  = ($urandom_range(0, 3) != 0) ? len_r - 1 : int'($urandom_range(0, len_r)) - 1;
            ak_r  = (len_r > 0 && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, len_r - 1)) : -1;
            run_cmd($sformatf("rand%0d", t), op_r, len_r, 2, 2, li_r, ak_r, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
